fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Front-end fetch unit sitting directly upstream of the instruction buffer.
- Maintains the fetch PC and issues one 32-bit instruction request at a time to instruction memory.
- Samples the branch predictor at request time, picks the next PC, and pushes {pc, inst, prediction, GHR snapshot} into the instruction buffer.
- Handles backend redirects, including squashing an in-flight memory response.

Parameters:
- GH, 8, global history width; must match the instruction buffer GH.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clock  in  1  single clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset.
- redirect_i  in  1  backend redirect (mispredict or exception).
- redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- mem_req_o  out  1  instruction fetch request valid.
- mem_addr_o  out  32  fetch address; word aligned.
- mem_req_ready_i  in  1  memory accepts the request this cycle.
- mem_resp_valid_i  in  1  response valid; arrives at least 1 cycle after acceptance, in order.
- mem_resp_data_i  in  32  instruction word.
- bp_lookup_pc_o  out  32  PC presented to the predictor; equals the current fetch PC.
- bp_pred_taken_i  in  1  combinational prediction for bp_lookup_pc_o.
- bp_pred_target_i  in  32  predicted target.
- bp_ghr_i  in  GH  predictor GHR snapshot for this lookup.
- ibuf_full_i  in  1  instruction buffer full.
- push_o  out  1  write one entry into the instruction buffer.
- push_pc_o  out  32  PC of the pushed instruction.
- push_inst_o  out  32  raw instruction.
- push_bp_pred_taken_o  out  1  captured prediction.
- push_bp_pred_target_o  out  32  captured target.
- push_bp_ghr_snapshot_o  out  GH  captured GHR.

Behaviour:
- State machine states:
  - REQ: request pending.
  - WAIT: request accepted, awaiting response.
  - HOLD: response latched, instruction buffer full.
- Registers: pc, inflight {pc, taken, target, ghr}, hold_inst, drop flag.
- Reset (reset_n=0 at a posedge): state=REQ, pc=RESET_PC, drop=0, inflight/hold registers cleared.
- While reset_n=0, mem_req_o=0 and push_o=0 combinationally; all other outputs are don't-care but driven to 0.
- REQ:
  - mem_req_o=1, mem_addr_o=pc, bp_lookup_pc_o=pc.
  - On mem_req_ready_i: capture pc and bp_* into inflight; next pc = bp_pred_taken_i ? {bp_pred_target_i[31:2],2'b00} : pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0); go to WAIT.
  - Otherwise stay in REQ with address stable.
- WAIT:
  - mem_req_o=0.
  - On mem_resp_valid_i with drop=1: discard the response, clear drop, go to REQ.
  - On mem_resp_valid_i with drop=0 and !ibuf_full_i: push_o=1 in the same cycle, push_inst_o=mem_resp_data_i, other push_* from inflight; go to REQ.
  - On mem_resp_valid_i with drop=0 and ibuf_full_i: latch data into hold_inst, go to HOLD.
- HOLD:
  - push_o = !ibuf_full_i, with push data from hold_inst/inflight.
  - On push, go to REQ; otherwise stay in HOLD.
- Throughput: at most one instruction every 2 cycles; minimum push is 1 cycle after acceptance.
- push_o is never asserted when ibuf_full_i=1.
- Redirect has priority over everything in the same cycle:
  - pc <= {redirect_pc_i[31:2],2'b00}; push_o forced 0 that cycle.
  - In REQ without acceptance: go to REQ; the new PC is presented next cycle.
  - In REQ with acceptance in the same cycle: the accepted request is squashed; set drop=1, go to WAIT.
  - In WAIT with mem_resp_valid_i in the same cycle: discard the response, drop=0, go to REQ.
  - In WAIT without a response: set drop=1, stay in WAIT.
  - In HOLD: discard the held instruction, go to REQ.
- Back-to-back redirects: the last one wins; drop stays 1 until the squashed response returns.
- mem_resp_valid_i in REQ or HOLD is a protocol error; it is ignored.

Test Plan:
- Reset with RESET_PC=0x100, memory ready always, 1-cycle response, no predictions -> pushes at PCs 0x100, 0x104, 0x108 with matching inst, push_o every 2 cycles.
- Predictor returns taken, target 0x2002, at PC 0x104 -> entry 0x104 pushed with taken=1, target=0x2002; next fetch address 0x2000.
- ibuf_full_i=1 for 5 cycles when the response for 0x108 arrives -> HOLD, no push while full, pushed once in the cycle full drops; no duplicate, no loss.
- Redirect to 0x400 in WAIT, response arrives 3 cycles later -> stale instruction never pushed; next request address 0x400, first push pc=0x400.
- Redirect coincident with the response, and redirect during HOLD -> no push that cycle; next fetch at redirect_pc; held entry discarded.
- reset_n=0 asserted mid-WAIT -> next cycle mem_req_o=0, push_o=0; after release, fetch restarts at RESET_PC and no late response is pushed.

Source files
------------

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Single-outstanding instruction fetch unit feeding the instruction
//            buffer, with branch-prediction sampling and redirect squashing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int          GH       = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    output logic          mem_req_o,
    output logic [31:0]   mem_addr_o,
    input  logic          mem_req_ready_i,
    input  logic          mem_resp_valid_i,
    input  logic [31:0]   mem_resp_data_i,
    output logic [31:0]   bp_lookup_pc_o,
    input  logic          bp_pred_taken_i,
    input  logic [31:0]   bp_pred_target_i,
    input  logic [GH-1:0] bp_ghr_i,
    input  logic          ibuf_full_i,
    output logic          push_o,
    output logic [31:0]   push_pc_o,
    output logic [31:0]   push_inst_o,
    output logic          push_bp_pred_taken_o,
    output logic [31:0]   push_bp_pred_target_o,
    output logic [GH-1:0] push_bp_ghr_snapshot_o
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight_taken;
    logic [31:0]   inflight_target;
    logic [GH-1:0] inflight_ghr;
    logic [31:0]   hold_inst;
    logic          drop;

    logic          accept;
    logic          resp_push;
    logic          hold_push;
    logic [31:0]   next_seq_pc;

    assign accept      = (state == REQ) && mem_req_ready_i;
    assign resp_push   = (state == WAIT) && mem_resp_valid_i && !drop && !ibuf_full_i;
    assign hold_push   = (state == HOLD) && !ibuf_full_i;
    assign next_seq_pc = bp_pred_taken_i ? {bp_pred_target_i[31:2], 2'b00} : pc + 32'd4;

    always_comb begin
        mem_req_o              = 1'b0;
        mem_addr_o             = '0;
        bp_lookup_pc_o         = '0;
        push_o                 = 1'b0;
        push_pc_o              = '0;
        push_inst_o            = '0;
        push_bp_pred_taken_o   = 1'b0;
        push_bp_pred_target_o  = '0;
        push_bp_ghr_snapshot_o = '0;
        if (reset_n) begin
            mem_req_o              = (state == REQ);
            mem_addr_o             = pc;
            bp_lookup_pc_o         = pc;
            // A redirect in the same cycle always wins over a push.
            push_o                 = !redirect_i && (resp_push || hold_push);
            push_pc_o              = inflight_pc;
            push_inst_o            = (state == HOLD) ? hold_inst : mem_resp_data_i;
            push_bp_pred_taken_o   = inflight_taken;
            push_bp_pred_target_o  = inflight_target;
            push_bp_ghr_snapshot_o = inflight_ghr;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= REQ;
            pc              <= RESET_PC;
            drop            <= 1'b0;
            inflight_pc     <= '0;
            inflight_taken  <= 1'b0;
            inflight_target <= '0;
            inflight_ghr    <= '0;
            hold_inst       <= '0;
        end else if (redirect_i) begin
            pc <= {redirect_pc_i[31:2], 2'b00};
            case (state)
                REQ: begin
                    if (mem_req_ready_i) begin
                        // Request already left; its response must be swallowed.
                        drop  <= 1'b1;
                        state <= WAIT;
                    end else begin
                        state <= REQ;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid_i) begin
                        drop  <= 1'b0;
                        state <= REQ;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (accept) begin
                        inflight_pc     <= pc;
                        inflight_taken  <= bp_pred_taken_i;
                        inflight_target <= bp_pred_target_i;
                        inflight_ghr    <= bp_ghr_i;
                        pc              <= next_seq_pc;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid_i) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else if (!ibuf_full_i) begin
                            state <= REQ;
                        end else begin
                            hold_inst <= mem_resp_data_i;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!ibuf_full_i) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam int GH = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_req_ready_i;
    logic          mem_resp_valid_i;
    logic [31:0]   mem_resp_data_i;
    logic [31:0]   bp_lookup_pc_o;
    logic          bp_pred_taken_i;
    logic [31:0]   bp_pred_target_i;
    logic [GH-1:0] bp_ghr_i;
    logic          ibuf_full_i;
    logic          push_o;
    logic [31:0]   push_pc_o;
    logic [31:0]   push_inst_o;
    logic          push_bp_pred_taken_o;
    logic [31:0]   push_bp_pred_target_o;
    logic [GH-1:0] push_bp_ghr_snapshot_o;

    int compared   = 0;
    int mismatched = 0;

    fetch_stage #(.GH(GH), .RESET_PC(32'h0000_0100)) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .redirect_i             (redirect_i),
        .redirect_pc_i          (redirect_pc_i),
        .mem_req_o              (mem_req_o),
        .mem_addr_o             (mem_addr_o),
        .mem_req_ready_i        (mem_req_ready_i),
        .mem_resp_valid_i       (mem_resp_valid_i),
        .mem_resp_data_i        (mem_resp_data_i),
        .bp_lookup_pc_o         (bp_lookup_pc_o),
        .bp_pred_taken_i        (bp_pred_taken_i),
        .bp_pred_target_i       (bp_pred_target_i),
        .bp_ghr_i               (bp_ghr_i),
        .ibuf_full_i            (ibuf_full_i),
        .push_o                 (push_o),
        .push_pc_o              (push_pc_o),
        .push_inst_o            (push_inst_o),
        .push_bp_pred_taken_o   (push_bp_pred_taken_o),
        .push_bp_pred_target_o  (push_bp_pred_target_o),
        .push_bp_ghr_snapshot_o (push_bp_ghr_snapshot_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n          = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hDEAD_BEEF;
        bp_pred_taken_i  = 1'b0;
        bp_pred_target_i = '0;
        bp_ghr_i         = '0;
        ibuf_full_i      = 1'b0;
        #1;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_push", {31'd0, push_o}, 32'd0);
        tick();
        tick();
        chk("rst_req2", {31'd0, mem_req_o}, 32'd0);
        reset_n          = 1'b1;
        mem_resp_valid_i = 1'b0;
        #1;
        // First request at RESET_PC
        chk("a_req", {31'd0, mem_req_o}, 32'd1);
        chk("a_addr", mem_addr_o, 32'h100);
        chk("a_lookup", bp_lookup_pc_o, 32'h100);
        chk("a_push", {31'd0, push_o}, 32'd0);
        tick();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hAAAA_0100;
        #1;
        chk("b_req", {31'd0, mem_req_o}, 32'd0);
        chk("b_push", {31'd0, push_o}, 32'd1);
        chk("b_pc", push_pc_o, 32'h100);
        chk("b_inst", push_inst_o, 32'hAAAA_0100);
        chk("b_taken", {31'd0, push_bp_pred_taken_o}, 32'd0);
        tick();
        // Predicted taken at 0x104
        mem_resp_valid_i = 1'b0;
        bp_pred_taken_i  = 1'b1;
        bp_pred_target_i = 32'h2002;
        bp_ghr_i         = 8'h5A;
        #1;
        chk("c_addr", mem_addr_o, 32'h104);
        chk("c_push", {31'd0, push_o}, 32'd0);
        tick();
        bp_pred_taken_i  = 1'b0;
        bp_pred_target_i = '0;
        bp_ghr_i         = '0;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hAAAA_0104;
        #1;
        chk("d_push", {31'd0, push_o}, 32'd1);
        chk("d_pc", push_pc_o, 32'h104);
        chk("d_inst", push_inst_o, 32'hAAAA_0104);
        chk("d_taken", {31'd0, push_bp_pred_taken_o}, 32'd1);
        chk("d_target", push_bp_pred_target_o, 32'h2002);
        chk("d_ghr", {24'd0, push_bp_ghr_snapshot_o}, 32'h5A);
        tick();
        mem_resp_valid_i = 1'b0;
        #1;
        chk("e_addr", mem_addr_o, 32'h2000);
        tick();
        // Response arrives while buffer full -> HOLD
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hAAAA_2000;
        ibuf_full_i      = 1'b1;
        #1;
        chk("f_push_full", {31'd0, push_o}, 32'd0);
        tick();
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_push", {31'd0, push_o}, 32'd0);
            chk("hold_req", {31'd0, mem_req_o}, 32'd0);
            tick();
        end
        ibuf_full_i = 1'b0;
        #1;
        chk("hold_release", {31'd0, push_o}, 32'd1);
        chk("hold_pc", push_pc_o, 32'h2000);
        chk("hold_inst", push_inst_o, 32'hAAAA_2000);
        tick();
        #1;
        chk("after_hold_push", {31'd0, push_o}, 32'd0);
        chk("after_hold_addr", mem_addr_o, 32'h2004);
        tick();
        // Redirect in WAIT without a response; stale response later
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h403;
        #1;
        chk("rw_push", {31'd0, push_o}, 32'd0);
        tick();
        redirect_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rw_wait_req", {31'd0, mem_req_o}, 32'd0);
            tick();
        end
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hBAD0_2004;
        #1;
        chk("rw_stale_push", {31'd0, push_o}, 32'd0);
        tick();
        mem_resp_valid_i = 1'b0;
        #1;
        chk("rw_req", {31'd0, mem_req_o}, 32'd1);
        chk("rw_addr", mem_addr_o, 32'h400);
        tick();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hAAAA_0400;
        #1;
        chk("rw_push_new", {31'd0, push_o}, 32'd1);
        chk("rw_push_pc", push_pc_o, 32'h400);
        chk("rw_push_inst", push_inst_o, 32'hAAAA_0400);
        tick();
        // Redirect coincident with acceptance
        mem_resp_valid_i = 1'b0;
        redirect_i       = 1'b1;
        redirect_pc_i    = 32'h800;
        #1;
        chk("ra_push", {31'd0, push_o}, 32'd0);
        tick();
        redirect_i       = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hBAD0_0404;
        #1;
        chk("ra_squash", {31'd0, push_o}, 32'd0);
        tick();
        mem_resp_valid_i = 1'b0;
        #1;
        chk("ra_addr", mem_addr_o, 32'h800);
        tick();
        // Redirect coincident with the response
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hAAAA_0800;
        redirect_i       = 1'b1;
        redirect_pc_i    = 32'hC00;
        #1;
        chk("rr_push", {31'd0, push_o}, 32'd0);
        tick();
        redirect_i       = 1'b0;
        mem_resp_valid_i = 1'b0;
        #1;
        chk("rr_addr", mem_addr_o, 32'hC00);
        chk("rr_req", {31'd0, mem_req_o}, 32'd1);
        tick();
        // Redirect during HOLD
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hAAAA_0C00;
        ibuf_full_i      = 1'b1;
        #1;
        chk("rh_full", {31'd0, push_o}, 32'd0);
        tick();
        mem_resp_valid_i = 1'b0;
        ibuf_full_i      = 1'b0;
        redirect_i       = 1'b1;
        redirect_pc_i    = 32'h1000;
        #1;
        chk("rh_push", {31'd0, push_o}, 32'd0);
        tick();
        redirect_i = 1'b0;
        #1;
        chk("rh_addr", mem_addr_o, 32'h1000);
        chk("rh_nopush", {31'd0, push_o}, 32'd0);
        tick();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hAAAA_1000;
        #1;
        chk("rh_next_pc", push_pc_o, 32'h1000);
        chk("rh_next_inst", push_inst_o, 32'hAAAA_1000);
        tick();
        // Memory not ready: address must stay stable
        mem_resp_valid_i = 1'b0;
        mem_req_ready_i  = 1'b0;
        #1;
        chk("nr_addr0", mem_addr_o, 32'h1004);
        tick();
        #1;
        chk("nr_addr1", mem_addr_o, 32'h1004);
        chk("nr_req1", {31'd0, mem_req_o}, 32'd1);
        mem_req_ready_i = 1'b1;
        tick();
        // Reset asserted mid-WAIT
        reset_n = 1'b0;
        #1;
        chk("mr_req", {31'd0, mem_req_o}, 32'd0);
        chk("mr_push", {31'd0, push_o}, 32'd0);
        tick();
        reset_n          = 1'b1;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hBAD0_1004;
        #1;
        chk("mr_late_push", {31'd0, push_o}, 32'd0);
        chk("mr_addr", mem_addr_o, 32'h100);
        chk("mr_req2", {31'd0, mem_req_o}, 32'd1);
        tick();
        mem_resp_data_i = 32'hAAAA_0100;
        #1;
        chk("mr_push2", {31'd0, push_o}, 32'd1);
        chk("mr_push_pc", push_pc_o, 32'h100);
        tick();
        // PC wrap at top of address space
        mem_resp_valid_i = 1'b0;
        mem_req_ready_i  = 1'b0;
        redirect_i       = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFE;
        tick();
        redirect_i      = 1'b0;
        mem_req_ready_i = 1'b1;
        #1;
        chk("wr_addr", mem_addr_o, 32'hFFFF_FFFC);
        tick();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hAAAA_FFFC;
        #1;
        chk("wr_push_pc", push_pc_o, 32'hFFFF_FFFC);
        tick();
        mem_resp_valid_i = 1'b0;
        #1;
        chk("wr_next", mem_addr_o, 32'h0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
